compare_arbiter: RTL and testbench
==================================

COMPARE_ARBITER -- requirements
Module: compare_arbiter

Interface
REQ-001 Parameter W, default 16, operand width in bits; unsigned.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an operand pair pending.
REQ-005 req0_a  input  W  requester 0 operand A.
REQ-006 req0_b  input  W  requester 0 operand B.
REQ-007 req0_ready  output  1  requester 0 pair accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_ready SHALL mirror REQ-004..007 for requester 1.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_id  output  1  requester that owns the result (0 or 1).
REQ-012 res_lt, res_eq, res_gt  output  1 each  A<B, A==B, A>B for the owning pair.

Function
REQ-013 The block SHALL share a single unsigned W-bit magnitude compare between two requesters, one transaction in flight at a time.
REQ-014 FSM states SHALL be IDLE, CMP and RESP.
REQ-015 IDLE: if any reqN_valid=1, the block SHALL grant one requester, assert its reqN_ready in that same cycle, capture its A/B and N into registers, and move to CMP; otherwise stay in IDLE.
REQ-016 reqN_ready SHALL be combinational: 1 only in IDLE for the granted requester; never both at once; 0 in CMP and RESP.
REQ-017 Grant: only one valid -> that requester; both valid -> the requester not equal to last_grant.
REQ-018 last_grant SHALL update to the granted ID on every accept.
REQ-019 CMP: the block SHALL register lt/eq/gt from the captured operands and go to RESP after exactly one cycle.
REQ-020 RESP: res_valid=1; res_id and flags SHALL stay stable until a cycle with res_ready=1, after which the state SHALL return to IDLE.
REQ-021 Latency: accept at cycle T -> res_valid=1 at T+2; with res_ready tied high, the minimum accept-to-accept spacing SHALL be 3 cycles.
REQ-022 While res_valid=1, exactly one of res_lt/res_eq/res_gt SHALL be 1; while res_valid=0, all three and res_id SHALL be 0.
REQ-023 Boundaries: A=B=0 and A=B=2^W-1 -> eq; 0 vs 2^W-1 -> lt (unsigned; no sign interpretation).
REQ-024 Requesters SHALL hold valid and operands stable until ready; the block SHALL sample operands only in the accept cycle.
REQ-025 Deasserting valid while not granted SHALL leave that request unserved; the block SHALL not record it.
REQ-026 A new request arriving in CMP or RESP SHALL wait; it is evaluated in the next IDLE cycle.

Reset
REQ-027 rst=1 at a clock edge SHALL force state=IDLE, last_grant=1 (requester 0 wins the first tie), res_valid=0, res_id=0, flags=0, and captured operands=0.
REQ-028 While rst=1, req0_ready and req1_ready SHALL be 0.
REQ-029 rst in CMP or RESP SHALL discard the in-flight transaction with no result emitted; normal operation SHALL resume on the first cycle after rst deasserts.

Verification
REQ-030 Single: req0 A=0x1234, B=0x1234 -> req0_ready at T; at T+2 res_valid=1, res_id=0, eq=1.
REQ-031 Tie after reset: both valid, req0 A=5/B=9, req1 A=0xFFFF/B=0 -> order res_id 0 (lt), then 1 (gt); a repeated tie alternates 0,1,0,1.
REQ-032 Backpressure: res_ready=0 for 4 cycles in RESP -> res_valid, res_id and flags stable; both reqN_ready=0; then res_ready=1 -> IDLE next cycle.
REQ-033 Unsigned corners: A=0x0000/B=0xFFFF -> lt; A=0x8000/B=0x7FFF -> gt; A=B=0xFFFF -> eq.
REQ-034 Reset mid-flight: rst=1 during CMP -> res_valid never asserts for that pair; after release, req1 alone is served with res_id=1.
REQ-035 Every cycle, an assertion SHALL check: flags one-hot when res_valid=1; flags and res_id 0 when res_valid=0; never both readys high.

Source files
------------

// File: rtl/compare_arbiter_if.sv
// Handshake bundle for compare_arbiter: two operand-pair requesters
// and one result channel. The arbiter connects through the slave
// modport. The requesters and the consumer use the master modport.
interface compare_arbiter_if #(
    parameter int unsigned W = 16
);
    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;

    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;

    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic         res_lt;
    logic         res_eq;
    logic         res_gt;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_id, res_lt, res_eq, res_gt,
        input  res_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_id, res_lt, res_eq, res_gt,
        output res_ready
    );
endinterface

// File: rtl/compare_arbiter.sv
// Two-requester arbiter sharing one unsigned W-bit magnitude comparator.
// Only one transaction is in flight at a time: IDLE accepts, CMP evaluates,
// and RESP holds the result until the consumer takes it.
// When both requesters are valid, the grant alternates between them.
module compare_arbiter #(
    parameter int unsigned W = 16
) (
    input  logic                clk,
    input  logic                rst,
    compare_arbiter_if.slave    bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMP  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]   state_q,      state_d;
    logic         last_grant_q, last_grant_d;
    logic [W-1:0] cap_a_q,      cap_a_d;
    logic [W-1:0] cap_b_q,      cap_b_d;
    logic         cap_id_q,     cap_id_d;
    logic         lt_q,         lt_d;
    logic         eq_q,         eq_d;
    logic         gt_q,         gt_d;

    logic         grant_valid;
    logic         grant_id;

    // Grant selection: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        grant_valid = (state_q == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    // Next-state, operand capture and compare evaluation
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cap_a_d      = cap_a_q;
        cap_b_d      = cap_b_q;
        cap_id_d     = cap_id_q;
        lt_d         = lt_q;
        eq_d         = eq_q;
        gt_d         = gt_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d      = CMP;
                    last_grant_d = grant_id;
                    cap_id_d     = grant_id;
                    cap_a_d      = grant_id ? bus.req1_a : bus.req0_a;
                    cap_b_d      = grant_id ? bus.req1_b : bus.req0_b;
                end
            end
            CMP: begin
                lt_d    = (cap_a_q <  cap_b_q);
                eq_d    = (cap_a_q == cap_b_q);
                gt_d    = (cap_a_q >  cap_b_q);
                state_d = RESP;
            end
            RESP: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            cap_a_q      <= '0;
            cap_b_q      <= '0;
            cap_id_q     <= 1'b0;
            lt_q         <= 1'b0;
            eq_q         <= 1'b0;
            gt_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cap_a_q      <= cap_a_d;
            cap_b_q      <= cap_b_d;
            cap_id_q     <= cap_id_d;
            lt_q         <= lt_d;
            eq_q         <= eq_d;
            gt_q         <= gt_d;
        end
    end

    // Output drive: readys only for the granted requester; result fields
    // are forced low whenever no result is being offered
    always_comb begin
        bus.req0_ready = grant_valid && !grant_id;
        bus.req1_ready = grant_valid &&  grant_id;
        bus.res_valid  = (state_q == RESP);
        bus.res_id     = bus.res_valid && cap_id_q;
        bus.res_lt     = bus.res_valid && lt_q;
        bus.res_eq     = bus.res_valid && eq_q;
        bus.res_gt     = bus.res_valid && gt_q;
    end

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed testbench for compare_arbiter with hand-computed expectations.
module tb_compare_arbiter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    compare_arbiter_if #(.W(16)) bus();

    compare_arbiter #(.W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants checked on every falling edge
    always @(negedge clk) begin
        checks++;
        if (bus.res_valid === 1'b1) begin
            if ($countones({bus.res_lt, bus.res_eq, bus.res_gt}) != 1) begin
                errors++;
                $display("FAIL inv_onehot flags=%b required one-hot", {bus.res_lt, bus.res_eq, bus.res_gt});
            end
        end else if ({bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt} !== 4'b0000) begin
            errors++;
            $display("FAIL inv_idle_zero id_flags=%b required 0000", {bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt});
        end
        checks++;
        if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin
            errors++;
            $display("FAIL inv_both_ready r0=%b r1=%b required not both", bus.req0_ready, bus.req1_ready);
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 16'h0001; bus.req0_b = 16'h0002;
        bus.req1_valid = 1'b1; bus.req1_a = 16'h0003; bus.req1_b = 16'h0004;
        bus.res_ready = 1'b1;
        tick(); tick();
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready got=%b required 00", {bus.req0_ready, bus.req1_ready});
        end
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt} !== 5'b00000) begin
            errors++; $display("FAIL reset_res got=%b required 00000",
                {bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt});
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // Both always valid: order must start with requester 0, then alternate
    task automatic test_tie();
        logic exp_id;
        tick();
        bus.req0_valid = 1'b1; bus.req0_a = 16'd5;    bus.req0_b = 16'd9;
        bus.req1_valid = 1'b1; bus.req1_a = 16'hFFFF; bus.req1_b = 16'h0000;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_id = k[0];
            #1;
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL tie_grant k=%0d got=%b required %b", k,
                    {bus.req0_ready, bus.req1_ready}, (exp_id ? 2'b01 : 2'b10));
            end
            tick(); #1;
            checks++;
            if ({bus.res_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
                errors++; $display("FAIL tie_cmp k=%0d got=%b required 000", k,
                    {bus.res_valid, bus.req0_ready, bus.req1_ready});
            end
            tick(); #1;
            checks++;
            if ({bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt} !==
                (exp_id ? 5'b11001 : 5'b10100)) begin
                errors++; $display("FAIL tie_res k=%0d got=%b required %b", k,
                    {bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt},
                    (exp_id ? 5'b11001 : 5'b10100));
            end
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // Single request with exact accept-to-result latency
    task automatic test_single();
        tick();
        bus.req0_valid = 1'b1; bus.req0_a = 16'h1234; bus.req0_b = 16'h1234;
        bus.res_ready = 1'b1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_accept got=%b required 10", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req0_valid = 1'b0;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL single_t1 res_valid=%b required 0", bus.res_valid);
        end
        tick(); #1;
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt} !== 5'b10010) begin
            errors++; $display("FAIL single_t2 got=%b required 10010",
                {bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt});
        end
        tick(); #1;
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL single_done res_valid=%b required 0", bus.res_valid);
        end
    endtask

    // Result held under backpressure; a request arriving in RESP waits for IDLE
    task automatic test_backpressure();
        tick();
        bus.req1_valid = 1'b1; bus.req1_a = 16'd7; bus.req1_b = 16'd2;
        bus.res_ready = 1'b0;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_accept got=%b required 01", {bus.req0_ready, bus.req1_ready});
        end
        tick();
        bus.req1_valid = 1'b0;
        tick();
        bus.req0_valid = 1'b1; bus.req0_a = 16'h0000; bus.req0_b = 16'hFFFF;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if ({bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt,
                 bus.req0_ready, bus.req1_ready} !== 7'b1100100) begin
                errors++; $display("FAIL bp_hold c=%0d got=%b required 1100100", c,
                    {bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt,
                     bus.req0_ready, bus.req1_ready});
            end
            tick();
        end
        bus.res_ready = 1'b1;
        tick(); #1;
        checks++;
        if ({bus.res_valid, bus.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_release got=%b required 01", {bus.res_valid, bus.req0_ready});
        end
        tick();
        bus.req0_valid = 1'b0;
        tick(); #1;
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt} !== 5'b10100) begin
            errors++; $display("FAIL bp_waiter got=%b required 10100",
                {bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt});
        end
        tick();
    endtask

    // Unsigned boundary operands through requester 0
    task automatic test_corners();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [2:0]  vf [4];
        va[0] = 16'h8000; vb[0] = 16'h7FFF; vf[0] = 3'b001;
        va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vf[1] = 3'b010;
        va[2] = 16'h0000; vb[2] = 16'h0000; vf[2] = 3'b010;
        va[3] = 16'h0000; vb[3] = 16'hFFFF; vf[3] = 3'b100;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.req0_valid = 1'b1; bus.req0_a = va[i]; bus.req0_b = vb[i];
            #1;
            checks++;
            if (bus.req0_ready !== 1'b1) begin
                errors++; $display("FAIL corner_accept i=%0d got=%b required 1", i, bus.req0_ready);
            end
            tick();
            bus.req0_valid = 1'b0;
            tick(); #1;
            checks++;
            if ({bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt} !== {2'b10, vf[i]}) begin
                errors++; $display("FAIL corner_res i=%0d got=%b required %b", i,
                    {bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt}, {2'b10, vf[i]});
            end
            tick();
        end
    endtask

    // Reset during CMP drops the pair; requester 1 is served afterwards
    task automatic test_reset_midflight();
        tick();
        bus.req0_valid = 1'b1; bus.req0_a = 16'd1; bus.req0_b = 16'd2;
        bus.res_ready = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_a = 16'd9; bus.req1_b = 16'd9;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
            errors++; $display("FAIL rstmid_ready got=%b required 00", {bus.req0_ready, bus.req1_ready});
        end
        tick(); #1;
        checks++;
        if ({bus.res_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
            errors++; $display("FAIL rstmid_held got=%b required 000",
                {bus.res_valid, bus.req0_ready, bus.req1_ready});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.res_valid, bus.req1_ready} !== 2'b01) begin
            errors++; $display("FAIL rstmid_resume got=%b required 01", {bus.res_valid, bus.req1_ready});
        end
        tick();
        bus.req1_valid = 1'b0;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_cmp res_valid=%b required 0", bus.res_valid);
        end
        tick(); #1;
        checks++;
        if ({bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt} !== 5'b11010) begin
            errors++; $display("FAIL rstmid_res got=%b required 11010",
                {bus.res_valid, bus.res_id, bus.res_lt, bus.res_eq, bus.res_gt});
        end
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.res_ready = 1'b0;
        test_reset();
        test_tie();
        test_single();
        test_backpressure();
        test_corners();
        test_reset_midflight();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
